// File: rtl/tone_mixer.sv
// rtl/tone_mixer.sv - time-multiplexed mixer of NUM_CHANNELS signed tone samples
//
// Purpose:
//   Accepts one set of NUM_CHANNELS signed samples per request and latches it.
//   It accumulates one channel per clock at full precision. It then averages
//   (arithmetic shift by log2 of the channel count) or passes the full sum
//   through. In both cases the result is clamped to the output range and
//   registered.
//
// Ports:
//   clk_in       system clock, rising edge
//   rst_in       synchronous active-high reset
//   samples_in   packed signed samples, channel i at [i*SAMPLE_WIDTH +: SAMPLE_WIDTH]
//   enable_in    per-channel enable
//   mode_in      0 = AVERAGE, 1 = SATURATE
//   valid_in     single-cycle mix request
//   busy_out     high while a mix is in flight
//   sample_out   signed mixed sample, held between updates
//   valid_out    one-cycle pulse when sample_out updates
//   clip_out     one-cycle pulse with valid_out when the clamp changed the value
//   overrun_out  one-cycle pulse (cycle after the drop) when valid_in arrived while busy

module tone_mixer #(
  parameter int NUM_CHANNELS = 4,
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] samples_in,
  input  logic [NUM_CHANNELS-1:0]              enable_in,
  input  logic                                 mode_in,
  input  logic                                 valid_in,
  output logic                                 busy_out,
  output logic [SAMPLE_WIDTH-1:0]              sample_out,
  output logic                                 valid_out,
  output logic                                 clip_out,
  output logic                                 overrun_out
);

  localparam int LOG2_CH = $clog2(NUM_CHANNELS);
  localparam int IDX_W   = (LOG2_CH < 1) ? 1 : LOG2_CH;
  // One extra bit above the worst-case sum growth keeps the sum exact.
  localparam int ACC_W   = SAMPLE_WIDTH + LOG2_CH + 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNELS - 1);

  // Output range expressed at accumulator width for the clamp comparison.
  localparam logic signed [ACC_W-1:0] MAX_V =
    {{(ACC_W-SAMPLE_WIDTH+1){1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V =
    {{(ACC_W-SAMPLE_WIDTH+1){1'b1}}, {(SAMPLE_WIDTH-1){1'b0}}};

  localparam logic [SAMPLE_WIDTH-1:0] OUT_MAX = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
  localparam logic [SAMPLE_WIDTH-1:0] OUT_MIN = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_OUTPUT = 2'd2
  } state_t;

  state_t                                       state_q, state_d;
  logic [NUM_CHANNELS-1:0][SAMPLE_WIDTH-1:0]    samp_q, samp_d;
  logic [NUM_CHANNELS-1:0]                      en_q, en_d;
  logic                                         mode_q, mode_d;
  logic signed [ACC_W-1:0]                      acc_q, acc_d;
  logic [IDX_W-1:0]                             idx_q, idx_d;
  logic [SAMPLE_WIDTH-1:0]                      sample_q, sample_d;
  logic                                         valid_q, valid_d;
  logic                                         clip_q, clip_d;
  logic                                         overrun_q, overrun_d;

  // Datapath helpers
  logic [SAMPLE_WIDTH-1:0]  cur_sample;
  logic signed [ACC_W-1:0]  cur_ext;
  logic signed [ACC_W-1:0]  scaled;
  logic [SAMPLE_WIDTH-1:0]  clamped;
  logic                     clamp_hit;

  // Current channel, sign-extended to accumulator width.
  always_comb begin
    cur_sample = samp_q[idx_q];
    cur_ext    = {{(ACC_W-SAMPLE_WIDTH){cur_sample[SAMPLE_WIDTH-1]}}, cur_sample};
  end

  // Scaling and clamp. The average is a plain arithmetic shift of the full
  // sum, so it rounds toward negative infinity. A non-power-of-two channel
  // count divides by the next power of two.
  always_comb begin
    scaled    = mode_q ? acc_q : (acc_q >>> LOG2_CH);
    clamped   = scaled[SAMPLE_WIDTH-1:0];
    clamp_hit = 1'b0;
    if (scaled > MAX_V) begin
      clamped   = OUT_MAX;
      clamp_hit = 1'b1;
    end else if (scaled < MIN_V) begin
      clamped   = OUT_MIN;
      clamp_hit = 1'b1;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d   = state_q;
    samp_d    = samp_q;
    en_d      = en_q;
    mode_d    = mode_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    sample_d  = sample_q;
    valid_d   = 1'b0;
    clip_d    = 1'b0;
    // A request that arrives mid-mix is dropped and reported.
    overrun_d = valid_in && (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (valid_in) begin
          samp_d  = samples_in;
          en_d    = enable_in;
          mode_d  = mode_in;
          acc_d   = '0;
          idx_d   = '0;
          state_d = ST_ACCUM;
        end
      end

      ST_ACCUM: begin
        if (en_q[idx_q]) begin
          acc_d = acc_q + cur_ext;
        end
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d = ST_OUTPUT;
        end
      end

      ST_OUTPUT: begin
        sample_d = clamped;
        valid_d  = 1'b1;
        clip_d   = clamp_hit;
        state_d  = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= ST_IDLE;
      samp_q    <= '0;
      en_q      <= '0;
      mode_q    <= 1'b0;
      acc_q     <= '0;
      idx_q     <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      clip_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      samp_q    <= samp_d;
      en_q      <= en_d;
      mode_q    <= mode_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      clip_q    <= clip_d;
      overrun_q <= overrun_d;
    end
  end

  assign busy_out    = (state_q != ST_IDLE);
  assign sample_out  = sample_q;
  assign valid_out   = valid_q;
  assign clip_out    = clip_q;
  assign overrun_out = overrun_q;

endmodule

// File: tb/tb_tone_mixer.sv
// tb/tb_tone_mixer.sv - scoreboard bench for tone_mixer

module tb_tone_mixer;

  localparam int NC = 4;
  localparam int SW = 16;

  logic                clk_in = 1'b0;
  logic                rst_in;
  logic [NC*SW-1:0]    samples_in;
  logic [NC-1:0]       enable_in;
  logic                mode_in;
  logic                valid_in;
  logic                busy_out;
  logic [SW-1:0]       sample_out;
  logic                valid_out;
  logic                clip_out;
  logic                overrun_out;

  tone_mixer #(.NUM_CHANNELS(NC), .SAMPLE_WIDTH(SW)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .samples_in  (samples_in),
    .enable_in   (enable_in),
    .mode_in     (mode_in),
    .valid_in    (valid_in),
    .busy_out    (busy_out),
    .sample_out  (sample_out),
    .valid_out   (valid_out),
    .clip_out    (clip_out),
    .overrun_out (overrun_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [SW-1:0] s;
    logic          c;
    int            t;
  } exp_t;

  exp_t sb[$];
  int   total   = 0;
  int   bad     = 0;
  int   cyc     = 0;
  int   ovr_cnt = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation for every valid_out pulse.
  always @(negedge clk_in) begin
    exp_t e;
    if (valid_out) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid actual=%0h required=none (cycle %0d)", sample_out, cyc);
      end else begin
        e = sb.pop_front();
        chk("sample", {16'h0, sample_out}, {16'h0, e.s});
        chk("clip", {31'h0, clip_out}, {31'h0, e.c});
        chk("latency_cycle", cyc, e.t);
      end
    end
    if (overrun_out) ovr_cnt++;
  end

  function automatic logic [NC*SW-1:0] pack4(input logic [SW-1:0] c0, c1, c2, c3);
    return {c3, c2, c1, c0};
  endfunction

  // Drives one request. With sync=1 it first moves to the next negedge.
  // The request is sampled at the following posedge, so valid_out is
  // expected at the negedge that is NC+2 posedges later than now.
  task automatic issue(input bit sync, input logic [NC*SW-1:0] s, input logic [NC-1:0] en,
                       input logic md, input bit push, input logic [SW-1:0] es,
                       input logic ec, input bit scramble);
    exp_t e;
    if (sync) @(negedge clk_in);
    samples_in = s;
    enable_in  = en;
    mode_in    = md;
    valid_in   = 1'b1;
    if (push) begin
      e.s = es;
      e.c = ec;
      e.t = cyc + NC + 2;
      sb.push_back(e);
    end
    @(negedge clk_in);
    valid_in = 1'b0;
    if (scramble) begin
      samples_in = {NC{16'h1234}};
      enable_in  = '0;
      mode_in    = ~md;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy_out) && n < 50) begin
      @(negedge clk_in);
      n++;
    end
    if (sb.size() != 0 || busy_out) begin
      total++;
      bad++;
      $display("FAIL drain_timeout actual=%0d pending required=0", sb.size());
      sb.delete();
    end
    @(negedge clk_in);
  endtask

  initial begin
    int o0;
    int n;
    rst_in     = 1'b1;
    samples_in = '0;
    enable_in  = '0;
    mode_in    = 1'b0;
    valid_in   = 1'b0;
    repeat (3) @(negedge clk_in);
    chk("rst_sample", {16'h0, sample_out}, 32'h0);
    chk("rst_valid", {31'h0, valid_out}, 32'h0);
    chk("rst_clip", {31'h0, clip_out}, 32'h0);
    chk("rst_overrun", {31'h0, overrun_out}, 32'h0);
    chk("rst_busy", {31'h0, busy_out}, 32'h0);
    rst_in = 1'b0;

    // AVERAGE, full scale, with busy window check
    issue(1, {NC{16'h4000}}, 4'b1111, 1'b0, 1, 16'h4000, 1'b0, 0);
    chk("busy_c1", {31'h0, busy_out}, 32'h1);
    for (int i = 2; i <= 5; i++) begin
      @(negedge clk_in);
      chk($sformatf("busy_c%0d", i), {31'h0, busy_out}, 32'h1);
    end
    @(negedge clk_in);
    chk("busy_c6", {31'h0, busy_out}, 32'h0);
    drain();

    // SATURATE positive / negative
    issue(1, {NC{16'h4000}}, 4'b1111, 1'b1, 1, 16'h7FFF, 1'b1, 0);
    drain();
    issue(1, {NC{16'h8000}}, 4'b1111, 1'b1, 1, 16'h8000, 1'b1, 0);
    drain();

    // Enables
    issue(1, pack4(16'd100, 16'd200, 16'd300, 16'd400), 4'b0101, 1'b1, 1, 16'd400, 1'b0, 0);
    drain();
    issue(1, pack4(16'd100, 16'd200, 16'd300, 16'd400), 4'b0000, 1'b1, 1, 16'd0, 1'b0, 0);
    drain();

    // Rounding toward negative infinity, inputs scrambled after acceptance
    issue(1, {NC{16'hFFFF}}, 4'b1111, 1'b0, 1, 16'hFFFF, 1'b0, 1);
    drain();
    issue(1, pack4(16'h0001, 16'h0000, 16'h0000, 16'h0000), 4'b1111, 1'b0, 1, 16'h0000, 1'b0, 0);
    drain();
    issue(1, {NC{16'h8000}}, 4'b1111, 1'b0, 1, 16'h8000, 1'b0, 0);
    drain();

    // Overrun: second request two cycles after acceptance is dropped
    o0 = ovr_cnt;
    issue(1, {NC{16'h7FFF}}, 4'b1111, 1'b0, 1, 16'h7FFF, 1'b0, 0);
    @(negedge clk_in);
    samples_in = {NC{16'h0100}};
    valid_in   = 1'b1;
    @(negedge clk_in);
    valid_in = 1'b0;
    drain();
    chk("overrun_pulses", ovr_cnt - o0, 32'd1);

    // Back-to-back: second request in the valid_out cycle is accepted
    o0 = ovr_cnt;
    issue(1, pack4(16'd10, 16'd20, 16'd30, 16'd40), 4'b1111, 1'b1, 1, 16'd100, 1'b0, 0);
    n = 0;
    while (!valid_out && n < 20) begin
      @(negedge clk_in);
      n++;
    end
    chk("b2b_valid_seen", {31'h0, valid_out}, 32'h1);
    issue(0, pack4(16'hFFF6, 16'd0, 16'd0, 16'd0), 4'b0001, 1'b1, 1, 16'hFFF6, 1'b0, 0);
    drain();
    chk("b2b_no_overrun", ovr_cnt - o0, 32'd0);

    // Reset mid-mix at edge k+2
    issue(1, {NC{16'h2000}}, 4'b1111, 1'b1, 0, 16'h0, 1'b0, 0);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    chk("mrst_sample", {16'h0, sample_out}, 32'h0);
    chk("mrst_busy", {31'h0, busy_out}, 32'h0);
    chk("mrst_valid", {31'h0, valid_out}, 32'h0);
    chk("mrst_clip", {31'h0, clip_out}, 32'h0);
    repeat (8) @(negedge clk_in);
    issue(1, pack4(16'd1, 16'd2, 16'd3, 16'd4), 4'b1110, 1'b1, 1, 16'd9, 1'b0, 0);
    drain();

    chk("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
